// File: rtl/seq_match_pkg.sv
// -----------------------------------------------------------------------------
// seq_match_pkg
// Shared types and helpers for the seq_match_sched block:
//   - state_e      : scheduler FSM state encoding (2 bits)
//   - DEF_PAT_LEN  : default pattern length
//   - DEF_PATTERN  : default pattern, right-aligned (MSB of the used slice is
//                    the first bit received)
//   - rr_pick      : cyclic first-set search used by the round-robin arbiter
// -----------------------------------------------------------------------------
package seq_match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int         DEF_PAT_LEN = 4;
  localparam logic [7:0] DEF_PATTERN = 8'b0000_1001;

  // Returns the first index at or after ptr (wrapping at n) whose req bit is
  // set. Supports up to 8 requesters; the caller gates the result with |req.
  function automatic logic [2:0] rr_pick(input logic [7:0]  req,
                                         input logic [2:0]  ptr,
                                         input int unsigned n);
    logic [2:0] sel;
    logic [2:0] idx;
    logic       found;
    sel   = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = 3'(({29'd0, ptr} + i) % n);
      if (!found && (i < n) && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/seq_match_sched_if.sv
// -----------------------------------------------------------------------------
// seq_match_sched_if
// Requester-side bus of the shared pattern matcher.
//   req        : per-requester request level
//   req_data   : requester i word at [i*DATA_W +: DATA_W]
//   grant      : one-hot grant pulse
//   busy       : job in progress (grant cycle through done cycle)
//   done       : result-valid pulse
//   done_id    : requester index of the finished job
//   match_cnt  : pattern occurrences in the finished job
// Modports: master = requesters, slave = scheduler.
// -----------------------------------------------------------------------------
interface seq_match_sched_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W + 1)
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        grant;
  logic                    busy;
  logic                    done;
  logic [ID_W-1:0]         done_id;
  logic [CNT_W-1:0]        match_cnt;

  modport master (
    output req, req_data,
    input  grant, busy, done, done_id, match_cnt
  );

  modport slave (
    input  req, req_data,
    output grant, busy, done, done_id, match_cnt
  );
endinterface

// File: rtl/seq_window_match.sv
// -----------------------------------------------------------------------------
// seq_window_match
// Serial PAT_LEN-bit window matcher. Bits arrive one per shift_en cycle; match
// pulses in the same cycle as the bit that completes the pattern.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   clr        : clears window history and fill counter
//   shift_en   : bit_in is valid this cycle
//   bit_in     : next serial bit
//   match      : combinational match pulse for the current bit
// Build option SEQ_MATCH_OVERLAP_EN: when defined, the window and fill are kept
// after a match so trailing bits may start the next occurrence; otherwise the
// window restarts after every match.
// -----------------------------------------------------------------------------
module seq_window_match #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic shift_en,
  input  logic bit_in,
  output logic match
);
  localparam int FILL_W = $clog2(PAT_LEN + 1);
  // Only the newest PAT_LEN-1 bits need storing; the oldest window bit is
  // always shifted out before the next compare.
  localparam int HIST_W = (PAT_LEN > 1) ? PAT_LEN - 1 : 1;

  logic [HIST_W-1:0]  r_hist;
  logic [HIST_W-1:0]  w_hist_nxt;
  logic [PAT_LEN-1:0] w_window_nxt;
  logic [FILL_W-1:0]  r_fill;
  logic [FILL_W-1:0]  w_fill_inc;

  generate
    if (PAT_LEN > 1) begin : g_multi
      assign w_window_nxt = {r_hist, bit_in};
      assign w_hist_nxt   = w_window_nxt[HIST_W-1:0];
    end else begin : g_single
      assign w_window_nxt = bit_in;
      assign w_hist_nxt   = 1'b0;
    end
  endgenerate

  // Fill saturates at PAT_LEN; it guards against matching a partly filled window.
  assign w_fill_inc = (r_fill == FILL_W'(PAT_LEN)) ? r_fill : r_fill + FILL_W'(1);
  assign match      = shift_en && (w_fill_inc == FILL_W'(PAT_LEN)) &&
                      (w_window_nxt == PATTERN);

  // Window history and fill counter update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (shift_en) begin
`ifdef SEQ_MATCH_OVERLAP_EN
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_inc;
`else
      if (match) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_hist_nxt;
        r_fill <= w_fill_inc;
      end
`endif
    end else begin
      r_hist <= r_hist;
      r_fill <= r_fill;
    end
  end

endmodule

// File: rtl/seq_match_sched.sv
// -----------------------------------------------------------------------------
// seq_match_sched
// Shares one serial pattern matcher among N_REQ requesters. A round-robin
// arbiter grants one requester, latches its word, shifts it MSB-first through
// seq_window_match and reports the occurrence count tagged with the id.
// Timing: grant at cycle T, LOAD at T+1, DATA_W SHIFT cycles, done at T+DATA_W+2.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : seq_match_sched_if.slave (req, req_data, grant, busy, done,
//           done_id, match_cnt)
// Build option SEQ_MATCH_OVERLAP_EN selects overlapping detection inside
// seq_window_match; ports and latency are identical in both builds.
// -----------------------------------------------------------------------------
module seq_match_sched
  import seq_match_pkg::*;
#(
  parameter int                 N_REQ   = 4,
  parameter int                 DATA_W  = 16,
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN[PAT_LEN-1:0],
  parameter int                 CNT_W   = $clog2(DATA_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  seq_match_sched_if.slave bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int BIT_W = $clog2(DATA_W + 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_req_any;
  logic              w_last_bit;
  logic              w_match;
  logic [ID_W-1:0]   w_sel;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   r_done_id;
  logic [N_REQ-1:0]  w_grant;
  logic              w_busy;
  logic [DATA_W-1:0] r_shreg;
  logic [BIT_W-1:0]  r_bit_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  r_match_cnt;
  logic              r_done;

  assign w_req_any  = |bus.req;
  assign w_sel      = ID_W'(rr_pick(8'(bus.req), 3'(r_ptr), N_REQ));
  assign w_ptr_nxt  = (w_sel == ID_W'(N_REQ - 1)) ? '0 : w_sel + ID_W'(1);
  assign w_last_bit = (r_bit_idx == BIT_W'(DATA_W - 1));
  // Count saturates at all-ones.
  assign w_cnt_nxt  = (w_match && (r_cnt != {CNT_W{1'b1}})) ? r_cnt + CNT_W'(1) : r_cnt;

  seq_window_match #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_win (
    .clk      (clk),
    .reset    (reset),
    .clr      (r_state == ST_LOAD),
    .shift_en (r_state == ST_SHIFT),
    .bit_in   (r_shreg[DATA_W-1]),
    .match    (w_match)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = w_req_any ? ST_LOAD : ST_IDLE;
      ST_LOAD:  w_state_nxt = ST_SHIFT;
      ST_SHIFT: w_state_nxt = w_last_bit ? ST_DONE : ST_SHIFT;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: grant is decided in the same IDLE cycle the request is seen.
  always_comb begin
    w_grant = '0;
    w_busy  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_any) begin
          w_grant = {{(N_REQ-1){1'b0}}, 1'b1} << w_sel;
          w_busy  = 1'b1;
        end else begin
          w_grant = '0;
          w_busy  = 1'b0;
        end
      end
      ST_LOAD, ST_SHIFT, ST_DONE: w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Datapath: arbiter pointer, job word/id, bit index, count and result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_shreg     <= '0;
      r_bit_idx   <= '0;
      r_cnt       <= '0;
      r_match_cnt <= '0;
      r_done_id   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_shreg <= bus.req_data[DATA_W*int'(w_sel) +: DATA_W];
            r_id    <= w_sel;
            r_ptr   <= w_ptr_nxt;
          end
        end
        ST_LOAD: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
        end
        ST_SHIFT: begin
          r_shreg   <= r_shreg << 1;
          r_cnt     <= w_cnt_nxt;
          r_bit_idx <= r_bit_idx + BIT_W'(1);
          // Result registers hold until the next job completes.
          if (w_last_bit) begin
            r_match_cnt <= w_cnt_nxt;
            r_done_id   <= r_id;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign bus.grant     = w_grant;
  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign bus.done_id   = r_done_id;
  assign bus.match_cnt = r_match_cnt;

endmodule

// File: tb/tb_seq_match_sched.sv
// -----------------------------------------------------------------------------
// tb_seq_match_sched
// Directed self-checking bench for seq_match_sched. A second instance with
// PATTERN = 4'b0000 exercises the fill guard. Expected counts that depend on
// SEQ_MATCH_OVERLAP_EN follow the same macro.
// -----------------------------------------------------------------------------
module tb_seq_match_sched;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

`ifdef SEQ_MATCH_OVERLAP_EN
  localparam int EXP_OVL  = 2;
  localparam int EXP_ZERO = 13;
`else
  localparam int EXP_OVL  = 1;
  localparam int EXP_ZERO = 4;
`endif

  seq_match_sched_if #(.N_REQ(4), .DATA_W(16), .CNT_W(5)) if_a ();
  seq_match_sched_if #(.N_REQ(4), .DATA_W(16), .CNT_W(5)) if_z ();

  seq_match_sched #(
    .N_REQ(4), .DATA_W(16), .PAT_LEN(4), .PATTERN(4'b1001), .CNT_W(5)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  seq_match_sched #(
    .N_REQ(4), .DATA_W(16), .PAT_LEN(4), .PATTERN(4'b0000), .CNT_W(5)
  ) u_zero (
    .clk   (clk),
    .reset (reset),
    .bus   (if_z)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset         = 1'b0;
    if_a.req      = 4'b0000;
    if_a.req_data = 64'd0;
    if_z.req      = 4'b0000;
    if_z.req_data = 64'd0;
    #1;
    n_cmp++; if (if_a.grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", if_a.grant); end
    n_cmp++; if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", if_a.busy); end
    n_cmp++; if (if_a.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", if_a.done); end
    n_cmp++; if (if_a.done_id !== 2'd0) begin n_fail++; $display("FAIL reset_done_id: got %0d want 0", if_a.done_id); end
    n_cmp++; if (if_a.match_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_match_cnt: got %0d want 0", if_a.match_cnt); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if ({if_a.grant, if_a.busy, if_a.done} !== 6'b000000) begin n_fail++; $display("FAIL idle_no_req: got %b want 000000", {if_a.grant, if_a.busy, if_a.done}); end
  endtask

  task automatic test_round_robin();
    int         g_cyc[5];
    logic [3:0] g_val[5];
    int         d_cyc[5];
    int         d_id[5];
    int         d_cnt[5];
    int         ng = 0;
    int         nd = 0;
    logic [3:0] eg;
    for (int j = 0; j < 5; j++) begin
      g_cyc[j] = -1; g_val[j] = 4'b0000; d_cyc[j] = -1; d_id[j] = -1; d_cnt[j] = -1;
    end
    @(negedge clk);
    if_a.req_data = {16'h9999, 16'h9990, 16'h9900, 16'h9000};
    if_a.req      = 4'b1111;
    for (int c = 0; c < 120 && nd < 5; c++) begin
      #1;
      if (if_a.grant !== 4'b0000 && ng < 5) begin
        g_cyc[ng] = c; g_val[ng] = if_a.grant; ng++;
      end
      if (if_a.done === 1'b1) begin
        d_cyc[nd] = c; d_id[nd] = int'(if_a.done_id); d_cnt[nd] = int'(if_a.match_cnt); nd++;
        if (nd == 5) if_a.req = 4'b0000;
      end
      @(negedge clk);
    end
    n_cmp++; if (ng !== 5) begin n_fail++; $display("FAIL rr_grant_count: got %0d want 5", ng); end
    n_cmp++; if (nd !== 5) begin n_fail++; $display("FAIL rr_done_count: got %0d want 5", nd); end
    for (int j = 0; j < 5; j++) begin
      eg = 4'b0001 << (j % 4);
      n_cmp++; if (g_val[j] !== eg) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", j, g_val[j], eg); end
      n_cmp++; if (g_cyc[j] !== 19 * j) begin n_fail++; $display("FAIL rr_grant_cycle[%0d]: got %0d want %0d", j, g_cyc[j], 19 * j); end
      n_cmp++; if (d_cyc[j] !== 19 * j + 18) begin n_fail++; $display("FAIL rr_done_cycle[%0d]: got %0d want %0d", j, d_cyc[j], 19 * j + 18); end
      n_cmp++; if (d_id[j] !== j % 4) begin n_fail++; $display("FAIL rr_done_id[%0d]: got %0d want %0d", j, d_id[j], j % 4); end
      n_cmp++; if (d_cnt[j] !== (j % 4) + 1) begin n_fail++; $display("FAIL rr_match_cnt[%0d]: got %0d want %0d", j, d_cnt[j], (j % 4) + 1); end
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    if_a.req_data[15:0] = 16'b1001_1001_0000_0000;
    if_a.req            = 4'b0001;
    #1;
    n_cmp++; if (if_a.grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", if_a.grant); end
    n_cmp++; if (if_a.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_T: got %b want 1", if_a.busy); end
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 1) if_a.req = 4'b0000;
      #1;
      if (k <= 17) begin
        n_cmp++; if ({if_a.grant, if_a.busy, if_a.done} !== 6'b000010) begin n_fail++; $display("FAIL single_run T+%0d: got gnt/busy/done %b want 000010", k, {if_a.grant, if_a.busy, if_a.done}); end
      end else if (k == 18) begin
        n_cmp++; if ({if_a.grant, if_a.done} !== 5'b00001) begin n_fail++; $display("FAIL single_done: got gnt/done %b want 00001", {if_a.grant, if_a.done}); end
        n_cmp++; if (if_a.done_id !== 2'd0) begin n_fail++; $display("FAIL single_done_id: got %0d want 0", if_a.done_id); end
        n_cmp++; if (if_a.match_cnt !== 5'd2) begin n_fail++; $display("FAIL single_match_cnt: got %0d want 2", if_a.match_cnt); end
      end else begin
        n_cmp++; if ({if_a.busy, if_a.done} !== 2'b00) begin n_fail++; $display("FAIL single_after: got busy/done %b want 00", {if_a.busy, if_a.done}); end
        n_cmp++; if (if_a.match_cnt !== 5'd2) begin n_fail++; $display("FAIL single_hold_cnt: got %0d want 2", if_a.match_cnt); end
      end
    end
  endtask

  task automatic test_overlap();
    @(negedge clk);
    if_a.req_data[15:0] = 16'b1001_0010_0000_0000;
    if_a.req            = 4'b0001;
    #1;
    n_cmp++; if (if_a.grant !== 4'b0001) begin n_fail++; $display("FAIL ovl_grant: got %b want 0001", if_a.grant); end
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) if_a.req = 4'b0000;
      #1;
      if (k == 18) begin
        n_cmp++; if (if_a.done !== 1'b1) begin n_fail++; $display("FAIL ovl_done: got %b want 1", if_a.done); end
        n_cmp++; if (if_a.match_cnt !== 5'(EXP_OVL)) begin n_fail++; $display("FAIL ovl_match_cnt: got %0d want %0d", if_a.match_cnt, EXP_OVL); end
      end
    end
  endtask

  task automatic test_zero_pattern();
    @(negedge clk);
    if_z.req_data[15:0] = 16'h0000;
    if_z.req            = 4'b0001;
    #1;
    n_cmp++; if (if_z.grant !== 4'b0001) begin n_fail++; $display("FAIL zero_grant: got %b want 0001", if_z.grant); end
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) if_z.req = 4'b0000;
      #1;
      if (k == 17) begin
        n_cmp++; if (if_z.done !== 1'b0) begin n_fail++; $display("FAIL zero_early_done: got %b want 0", if_z.done); end
      end else if (k == 18) begin
        n_cmp++; if (if_z.done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", if_z.done); end
        n_cmp++; if (if_z.match_cnt !== 5'(EXP_ZERO)) begin n_fail++; $display("FAIL zero_match_cnt: got %0d want %0d", if_z.match_cnt, EXP_ZERO); end
      end
    end
  endtask

  task automatic test_late_requester();
    @(negedge clk);
    if_a.req_data[15:0] = 16'h9000;
    if_a.req            = 4'b0001;
    #1;
    n_cmp++; if (if_a.grant !== 4'b0001) begin n_fail++; $display("FAIL late_grant0: got %b want 0001", if_a.grant); end
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if_a.req            = 4'b0000;
        if_a.req_data[15:0] = 16'h9999;
      end
      if (k == 5) begin
        if_a.req             = 4'b0010;
        if_a.req_data[31:16] = 16'h9900;
      end
      if (k == 20) if_a.req = 4'b0000;
      #1;
      if (k >= 5 && k <= 18) begin
        n_cmp++; if (if_a.grant !== 4'b0000) begin n_fail++; $display("FAIL late_ignored T+%0d: got %b want 0000", k, if_a.grant); end
      end
      if (k == 18) begin
        n_cmp++; if (if_a.done !== 1'b1) begin n_fail++; $display("FAIL late_done0: got %b want 1", if_a.done); end
        n_cmp++; if (if_a.done_id !== 2'd0) begin n_fail++; $display("FAIL late_done_id0: got %0d want 0", if_a.done_id); end
        n_cmp++; if (if_a.match_cnt !== 5'd1) begin n_fail++; $display("FAIL late_cnt0: got %0d want 1", if_a.match_cnt); end
      end else if (k == 19) begin
        n_cmp++; if (if_a.grant !== 4'b0010) begin n_fail++; $display("FAIL late_grant1: got %b want 0010", if_a.grant); end
      end else if (k == 37) begin
        n_cmp++; if (if_a.done !== 1'b1) begin n_fail++; $display("FAIL late_done1: got %b want 1", if_a.done); end
        n_cmp++; if (if_a.done_id !== 2'd1) begin n_fail++; $display("FAIL late_done_id1: got %0d want 1", if_a.done_id); end
        n_cmp++; if (if_a.match_cnt !== 5'd2) begin n_fail++; $display("FAIL late_cnt1: got %0d want 2", if_a.match_cnt); end
      end
    end
  endtask

  task automatic test_reset_mid_job();
    @(negedge clk);
    if_a.req_data[47:32] = 16'h9999;
    if_a.req             = 4'b0100;
    #1;
    n_cmp++; if (if_a.grant !== 4'b0100) begin n_fail++; $display("FAIL rst_grant2: got %b want 0100", if_a.grant); end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) if_a.req = 4'b0000;
      if (k == 9) reset = 1'b0;
      #1;
      if (k == 8) begin
        n_cmp++; if (if_a.busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_before: got %b want 1", if_a.busy); end
      end
    end
    n_cmp++; if ({if_a.grant, if_a.busy, if_a.done} !== 6'b000000) begin n_fail++; $display("FAIL rst_mid_ctrl: got %b want 000000", {if_a.grant, if_a.busy, if_a.done}); end
    n_cmp++; if (if_a.done_id !== 2'd0) begin n_fail++; $display("FAIL rst_mid_done_id: got %0d want 0", if_a.done_id); end
    n_cmp++; if (if_a.match_cnt !== 5'd0) begin n_fail++; $display("FAIL rst_mid_match_cnt: got %0d want 0", if_a.match_cnt); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      n_cmp++; if ({if_a.busy, if_a.done} !== 2'b00) begin n_fail++; $display("FAIL rst_hold[%0d]: got busy/done %b want 00", k, {if_a.busy, if_a.done}); end
    end
    @(negedge clk);
    if_a.req = 4'b1100;
    reset    = 1'b1;
    #1;
    // Pointer restarts at 0, so requester 2 wins over requester 3.
    n_cmp++; if (if_a.grant !== 4'b0100) begin n_fail++; $display("FAIL rst_ptr_grant: got %b want 0100", if_a.grant); end
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) if_a.req = 4'b0000;
      #1;
      if (k <= 17) begin
        n_cmp++; if (if_a.done !== 1'b0) begin n_fail++; $display("FAIL rst_no_done T+%0d: got %b want 0", k, if_a.done); end
      end else begin
        n_cmp++; if (if_a.done !== 1'b1) begin n_fail++; $display("FAIL rst_new_done: got %b want 1", if_a.done); end
        n_cmp++; if (if_a.done_id !== 2'd2) begin n_fail++; $display("FAIL rst_new_done_id: got %0d want 2", if_a.done_id); end
        n_cmp++; if (if_a.match_cnt !== 5'd4) begin n_fail++; $display("FAIL rst_new_cnt: got %0d want 4", if_a.match_cnt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_overlap();
    test_zero_pattern();
    test_late_requester();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_match_sched.md
Name: seq_match_sched

Overview:
- Shares one serial pattern matcher among N_REQ requesters.
- Each requester presents a DATA_W-bit word.
- The block grants requesters round-robin, latches the granted word, and shifts it MSB-first through a PAT_LEN-bit window matcher.
- It counts pattern occurrences and returns the count, tagged with the requester id.
- It sits above the serial detector and owns the detector's sequencing and its sharing between clients.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 16, bits per job word (>= PAT_LEN)
- PAT_LEN, 4, pattern length in bits (1..8)
- PATTERN, 4'b1001, pattern to detect, MSB = first bit received
- CNT_W, $clog2(DATA_W+1), width of the match count

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request level
- req_data  in  N_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W]
- grant  out  N_REQ  one-hot, 1-cycle pulse; that requester's word is latched
- busy  out  1  high from the grant cycle through the done cycle
- done  out  1  1-cycle pulse; result valid
- done_id  out  $clog2(N_REQ)  requester index of the finished job
- match_cnt  out  CNT_W  pattern occurrences in the finished job

Behaviour:
- Reset (reset low, async): FSM to IDLE; grant = 0, busy = 0, done = 0, done_id = 0, match_cnt = 0; round-robin pointer = 0; window, fill counter and bit counter cleared.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE, any req bit high:
  - Select the first requester at or after the pointer, searching cyclically.
  - Assert grant[sel] for that cycle and latch req_data slice into shift register, sel into id register.
  - Pointer <= sel+1 mod N_REQ.
  - Go to LOAD.
- IDLE, req == 0: stay in IDLE, pointer unchanged.
- LOAD (1 cycle):
  - Clear window, fill = 0, count = 0, bit index = 0.
  - Go to SHIFT.
- SHIFT, one bit per cycle, DATA_W cycles:
  - window <= {window[PAT_LEN-2:0], shreg MSB}; shreg shifts left.
  - fill increments and saturates at PAT_LEN.
  - A match is the new window == PATTERN with fill (after the increment) >= PAT_LEN; count increments on a match.
  - Non-overlap (default): on a match, fill <= 0 and the window restarts, so no bit belongs to two matches.
  - After bit DATA_W-1 is evaluated, go to DONE.
- DONE (1 cycle):
  - done = 1; done_id and match_cnt hold the job result.
  - match_cnt and done_id then hold their values until the next DONE.
  - Go to IDLE, so there is a minimum of 1 idle cycle between jobs.
- Latency: grant at cycle T; done at T+DATA_W+2.
- Requester handshake:
  - A requester holds req and req_data stable until it sees its grant.
  - It may drop req or change req_data from the cycle after grant.
  - req changes during a job are ignored. A req that drops before being granted is never serviced, and no error is flagged.
- The count saturates at 2**CNT_W-1. With the default CNT_W it is unreachable.
- Reset asserted mid-job aborts the job without a done pulse. After reset release the FSM resumes from IDLE with the pointer at 0.

Optional Feature:
- Macro: SEQ_MATCH_OVERLAP_EN.
- Defined: overlapping detection. On a match, fill is not cleared and the window is kept, so trailing bits can begin the next match.
- Undefined: non-overlapping detection as specified above.
- Ports and latency are identical in both builds.

Decomposition:
- Shared package seq_match_pkg:
  - FSM state enum (IDLE, LOAD, SHIFT, DONE) as a 2-bit typedef.
  - Default PATTERN / PAT_LEN constants.
  - A function for the round-robin next-index search.
- One sub-module, seq_window_match:
  - Contains window, fill counter and compare.
  - Inputs: clk, reset, clr, shift_en, bit_in.
  - Output: match pulse.
  - Overlap macro handled inside it.
- seq_match_sched contains the arbiter, FSM, data shift register and counter.

Test Plan:
- Single job, default params:
  - Stimulus: req=4'b0001, data0=16'b1001_1001_0000_0000.
  - Expected: grant=0001 at T; busy T..T+17; done at T+18 with done_id=0, match_cnt=2.
- Overlap vs non-overlap: data0=16'b1001_0010_0000_0000 -> match_cnt=1 without SEQ_MATCH_OVERLAP_EN, match_cnt=2 with it.
- Round robin: req=4'b1111 held for 5 jobs -> grant order 0,1,2,3,0, each 19 cycles apart; done_id sequence matches.
- Pattern-of-zeros guard:
  - Stimulus: PATTERN=4'b0000, data=16'h0000.
  - Expected: match_cnt=4 (non-overlap), 13 (overlap); no match counted before 4 bits received.
- Reset mid-job:
  - Stimulus: reset low at SHIFT bit 7 of a requester-2 job.
  - Expected: all outputs 0 immediately, no done pulse.
  - After release with req=4'b0100: grant=0100, pointer restarted from 0.
- Late requester: req=4'b0010 arrives during requester-0 SHIFT -> ignored until IDLE; granted the cycle after DONE; data0 changed after grant does not alter requester-0 result.
